// File: rtl/genexu_mul_div_issue.sv
// MUL_DIV EXU stream initiator: issues one M-extension op on the req stream,
// waits for its single-beat response and hands the result to the register-file writeback port.
package genexu_mul_div_issue_pkg;
    localparam int unsigned OPC_W = 3;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned RD_W  = 5;

    typedef struct packed {
        logic [OPC_W-1:0] exu_opcode;
        logic [XLEN-1:0]  src0_data;
        logic [XLEN-1:0]  src1_data;
    } req_struct;

    typedef struct packed {
        logic [XLEN-1:0] rd0_wdata;
    } resp_struct;
endpackage

module genexu_mul_div_issue
    import genexu_mul_div_issue_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [OPC_W-1:0]  cmd_opcode_i,
    input  logic [XLEN-1:0]   cmd_src0_i,
    input  logic [XLEN-1:0]   cmd_src1_i,
    input  logic [RD_W-1:0]   cmd_rd_i,
    input  logic              flush_i,
    output logic              stream_req_bus_genfifo_req_o,
    output req_struct         stream_req_bus_genfifo_wdata_bo,
    input  logic              stream_req_bus_genfifo_ack_i,
    input  logic              stream_resp_bus_genfifo_req_i,
    input  resp_struct        stream_resp_bus_genfifo_rdata_bi,
    output logic              stream_resp_bus_genfifo_ack_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              busy_o,
    output logic              err_timeout_o,
    output logic              err_stray_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    // Counter value seen in the last WAIT cycle before the watchdog fires
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             discard_q, discard_d;
    logic             timeout_d, stray_d;
    logic             cmd_accept, resp_capture;
    req_struct        req_q;
    logic [RD_W-1:0]  rd_q;
    logic [XLEN-1:0]  data_q;

    // State, watchdog counter, discard flag and error pulses
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            discard_q     <= 1'b0;
            err_timeout_o <= 1'b0;
            err_stray_o   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            discard_q     <= discard_d;
            err_timeout_o <= timeout_d;
            err_stray_o   <= stray_d;
        end
    end

    // Command latch (drives the request payload) and response capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_q  <= '0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            if (cmd_accept) begin
                req_q.exu_opcode <= cmd_opcode_i;
                req_q.src0_data  <= cmd_src0_i;
                req_q.src1_data  <= cmd_src1_i;
                rd_q             <= cmd_rd_i;
            end
            if (resp_capture) begin
                data_q <= stream_resp_bus_genfifo_rdata_bi.rd0_wdata;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        discard_d    = discard_q;
        timeout_d    = 1'b0;
        cmd_accept   = 1'b0;
        resp_capture = 1'b0;
        cmd_ready_o  = 1'b0;
        wb_valid_o   = 1'b0;
        stream_req_bus_genfifo_req_o = 1'b0;
        busy_o       = (state_q != S_IDLE);
        // Any response not consumed in WAIT is dropped and flagged
        stray_d      = stream_resp_bus_genfifo_req_i && (state_q != S_WAIT);

        unique case (state_q)
            S_IDLE: begin
                cmd_ready_o = !flush_i;
                if (cmd_valid_i && !flush_i) begin
                    cmd_accept = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                stream_req_bus_genfifo_req_o = 1'b1;
                // A same-cycle ack already handed the op to the EXU, so a flush can only discard it
                if (stream_req_bus_genfifo_ack_i) begin
                    state_d   = S_WAIT;
                    cnt_d     = '0;
                    discard_d = flush_i;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (flush_i) begin
                    discard_d = 1'b1;
                end
                if (stream_resp_bus_genfifo_req_i) begin
                    resp_capture = 1'b1;
                    discard_d    = 1'b0;
                    state_d      = (discard_q || flush_i || rd_q == '0) ? S_IDLE : S_WB;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    discard_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_WB: begin
                wb_valid_o  = 1'b1;
                cmd_ready_o = wb_ready_i && !flush_i;
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (wb_ready_i) begin
                    if (cmd_valid_i) begin
                        cmd_accept = 1'b1;
                        state_d    = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stream_req_bus_genfifo_wdata_bo = req_q;
    assign stream_resp_bus_genfifo_ack_o   = 1'b1;
    assign wb_rd_o                         = rd_q;
    assign wb_data_o                       = data_q;

endmodule

// File: tb/tb_genexu_mul_div_issue.sv
// Directed bench for genexu_mul_div_issue; the bench plays both the pipeline and the EXU,
// with request payloads and writebacks checked against scoreboard queues.
module tb_genexu_mul_div_issue;
    import genexu_mul_div_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [31:0] cmd_src0;
    logic [31:0] cmd_src1;
    logic [4:0]  cmd_rd;
    logic        flush;
    logic        req;
    req_struct   wdata;
    logic        ack;
    logic        resp;
    resp_struct  rdata;
    logic        resp_ack;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
    logic        err_timeout;
    logic        err_stray;

    int          checks = 0;
    int          errors = 0;
    req_struct   req_exp_q[$];
    logic [36:0] wb_exp_q[$];
    logic [31:0] cur_res;

    always #5 clk = ~clk;

    genexu_mul_div_issue #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk_i                            (clk),
        .rst_i                            (rst_i),
        .cmd_valid_i                      (cmd_valid),
        .cmd_ready_o                      (cmd_ready),
        .cmd_opcode_i                     (cmd_opcode),
        .cmd_src0_i                       (cmd_src0),
        .cmd_src1_i                       (cmd_src1),
        .cmd_rd_i                         (cmd_rd),
        .flush_i                          (flush),
        .stream_req_bus_genfifo_req_o     (req),
        .stream_req_bus_genfifo_wdata_bo  (wdata),
        .stream_req_bus_genfifo_ack_i     (ack),
        .stream_resp_bus_genfifo_req_i    (resp),
        .stream_resp_bus_genfifo_rdata_bi (rdata),
        .stream_resp_bus_genfifo_ack_o    (resp_ack),
        .wb_valid_o                       (wb_valid),
        .wb_ready_i                       (wb_ready),
        .wb_rd_o                          (wb_rd),
        .wb_data_o                        (wb_data),
        .busy_o                           (busy),
        .err_timeout_o                    (err_timeout),
        .err_stray_o                      (err_stray)
    );

    // Reference M-extension result, used as the emulated EXU's answer
    function automatic logic [31:0] mext(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        [63:0] p;
        logic signed [63:0] sa, sb, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 96'(obs), 96'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit exp_req, input bit exp_wb);
        req_struct r;
        cmd_valid    = 1'b1;
        cmd_opcode   = op;
        cmd_src0     = a;
        cmd_src1     = b;
        cmd_rd       = rd;
        cur_res      = mext(op, a, b);
        r.exu_opcode = op;
        r.src0_data  = a;
        r.src1_data  = b;
        if (exp_req) req_exp_q.push_back(r);
        if (exp_wb)  wb_exp_q.push_back({rd, cur_res});
    endtask

    // Scoreboard: compare every request and writeback handshake against the queues
    always @(negedge clk) begin
        if (rst_i === 1'b1) begin
            if (req && ack) begin
                chk1("req_pending", req_exp_q.size() != 0, 1'b1);
                if (req_exp_q.size() != 0) chk("req_payload", 96'(wdata), 96'(req_exp_q.pop_front()));
            end
            if (wb_valid && wb_ready) begin
                chk1("wb_pending", wb_exp_q.size() != 0, 1'b1);
                if (wb_exp_q.size() != 0) chk("wb_rd_data", 96'({wb_rd, wb_data}), 96'(wb_exp_q.pop_front()));
            end
        end
    end

    initial begin
        req_struct exp_div;
        rst_i = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_src0 = '0; cmd_src1 = '0;
        cmd_rd = '0; flush = 1'b0; ack = 1'b0; resp = 1'b0; rdata = '0; wb_ready = 1'b0;
        cur_res = '0;
        repeat (2) @(posedge clk);
        #4;
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_resp_ack", resp_ack, 1'b1);
        chk1("rst_req", req, 1'b0);
        chk1("rst_wb_valid", wb_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err_timeout", err_timeout, 1'b0);
        chk1("rst_err_stray", err_stray, 1'b0);
        chk("rst_wdata", 96'(wdata), 96'(0));
        chk("rst_wb_rd_data", 96'({wb_rd, wb_data}), 96'(0));
        step(); rst_i = 1'b1;

        // mul 7*6 -> rd5 = 42, ack with request, response two cycles later
        step(); issue(3'd0, 32'd7, 32'd6, 5'd5, 1, 1); settle();
        chk1("t1_cmd_ready", cmd_ready, 1'b1);
        step(); cmd_valid = 1'b0; ack = 1'b1; settle();
        chk1("t1_req_latency", req, 1'b1);
        step(); ack = 1'b0; settle();
        chk1("t1_req_drop", req, 1'b0);
        chk1("t1_busy_wait", busy, 1'b1);
        step(); resp = 1'b1; rdata.rd0_wdata = cur_res; settle();
        step(); resp = 1'b0; wb_ready = 1'b1; settle();
        chk1("t1_wb_valid", wb_valid, 1'b1);
        chk("t1_wb_data", 96'(wb_data), 96'(42));
        step(); wb_ready = 1'b0; settle();
        chk1("t1_wb_single_pulse", wb_valid, 1'b0);
        chk1("t1_idle", busy, 1'b0);

        // div 0x80000000 / -1 with ack held low for three cycles
        step(); issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1, 1); settle();
        exp_div.exu_opcode = 3'd4; exp_div.src0_data = 32'h8000_0000; exp_div.src1_data = 32'hFFFF_FFFF;
        step(); cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            settle();
            chk1("t2_req_held", req, 1'b1);
            chk("t2_wdata_stable", 96'(wdata), 96'(exp_div));
        end
        step(); ack = 1'b1; settle();
        step(); ack = 1'b0; settle();
        step(); resp = 1'b1; rdata.rd0_wdata = cur_res; settle();
        step(); resp = 1'b0; wb_ready = 1'b1; settle();
        chk("t2_wb_data", 96'(wb_data), 96'(32'h8000_0000));
        step(); wb_ready = 1'b0; settle();

        // writeback stalled 4 cycles, then a new op chains in with no bubble
        step(); issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1, 1); settle();
        step(); cmd_valid = 1'b0; ack = 1'b1; settle();
        step(); ack = 1'b0; resp = 1'b1; rdata.rd0_wdata = cur_res; settle();
        step(); resp = 1'b0; wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) step();
            settle();
            chk1("t3_wb_hold", wb_valid, 1'b1);
            chk1("t3_cmd_ready_low", cmd_ready, 1'b0);
        end
        chk("t3_wb_data_held", 96'(wb_data), 96'(32'hFFFF_FFFE));
        step(); wb_ready = 1'b1; issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd10, 1, 1); settle();
        chk1("t3_cmd_ready_chain", cmd_ready, 1'b1);
        step(); wb_ready = 1'b0; cmd_valid = 1'b0; ack = 1'b1; settle();
        chk1("t3_req_no_bubble", req, 1'b1);
        chk1("t3_wb_dropped", wb_valid, 1'b0);
        step(); ack = 1'b0; resp = 1'b1; rdata.rd0_wdata = cur_res; settle();
        step(); resp = 1'b0; wb_ready = 1'b1; settle();
        chk1("t3_wb2_valid", wb_valid, 1'b1);
        step(); wb_ready = 1'b0; settle();

        // flush in WAIT: response consumed, no writeback
        step(); issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd3, 1, 0); settle();
        step(); cmd_valid = 1'b0; ack = 1'b1; settle();
        step(); ack = 1'b0; flush = 1'b1; settle();
        step(); flush = 1'b0; resp = 1'b1; rdata.rd0_wdata = 32'h1234; settle();
        step(); resp = 1'b0; wb_ready = 1'b1; settle();
        chk1("t4_busy_low", busy, 1'b0);
        chk1("t4_no_wb", wb_valid, 1'b0);
        chk1("t4_no_stray", err_stray, 1'b0);
        step(); wb_ready = 1'b0; settle();

        // flush in REQ without ack: request withdrawn
        step(); issue(3'd1, 32'd5, 32'd5, 5'd6, 0, 0); settle();
        step(); cmd_valid = 1'b0; flush = 1'b1; settle();
        chk1("t4b_req_up", req, 1'b1);
        step(); flush = 1'b0; settle();
        chk1("t4b_req_dropped", req, 1'b0);
        chk1("t4b_idle", busy, 1'b0);

        // watchdog: no response for 8 WAIT cycles, then a late response is stray
        step(); issue(3'd5, 32'd100, 32'd0, 5'd4, 1, 0); settle();
        step(); cmd_valid = 1'b0; ack = 1'b1; settle();
        for (int i = 0; i < 8; i++) begin
            step(); ack = 1'b0; settle();
            chk1("t5_waiting", busy, 1'b1);
            chk1("t5_no_timeout_yet", err_timeout, 1'b0);
        end
        step(); settle();
        chk1("t5_timeout_pulse", err_timeout, 1'b1);
        chk1("t5_timeout_idle", busy, 1'b0);
        step(); settle();
        chk1("t5_timeout_one_cycle", err_timeout, 1'b0);
        step(); resp = 1'b1; rdata.rd0_wdata = cur_res; settle();
        step(); resp = 1'b0; settle();
        chk1("t5_late_stray", err_stray, 1'b1);
        chk1("t5_stray_idle", busy, 1'b0);
        step(); settle();
        chk1("t5_stray_one_cycle", err_stray, 1'b0);

        // response during req&ack is stray; rd=0 op skips writeback
        step(); issue(3'd0, 32'd1, 32'd1, 5'd0, 1, 0); settle();
        step(); cmd_valid = 1'b0; ack = 1'b1; resp = 1'b1; rdata.rd0_wdata = 32'hDEAD; settle();
        step(); ack = 1'b0; resp = 1'b0; settle();
        chk1("t6_stray_same_cycle", err_stray, 1'b1);
        chk1("t6_still_waiting", busy, 1'b1);
        step(); resp = 1'b1; rdata.rd0_wdata = cur_res; settle();
        step(); resp = 1'b0; wb_ready = 1'b1; settle();
        chk1("t6_rd0_no_wb", wb_valid, 1'b0);
        chk1("t6_rd0_idle", busy, 1'b0);
        chk1("t6_no_stray", err_stray, 1'b0);
        step(); wb_ready = 1'b0; settle();

        // asynchronous reset in WAIT, then a stale response
        step(); issue(3'd0, 32'd3, 32'd5, 5'd2, 1, 0); settle();
        step(); cmd_valid = 1'b0; ack = 1'b1; settle();
        step(); ack = 1'b0; settle();
        chk1("t7_busy_before_rst", busy, 1'b1);
        #1 rst_i = 1'b0;
        #1;
        chk1("t7_rst_busy", busy, 1'b0);
        chk1("t7_rst_cmd_ready", cmd_ready, 1'b1);
        chk1("t7_rst_req", req, 1'b0);
        chk("t7_rst_wdata", 96'(wdata), 96'(0));
        step(); rst_i = 1'b1; settle();
        step(); resp = 1'b1; rdata.rd0_wdata = cur_res; settle();
        step(); resp = 1'b0; settle();
        chk1("t7_stray_after_rst", err_stray, 1'b1);
        chk1("t7_idle", busy, 1'b0);

        step(); settle();
        chk("req_queue_drained", 96'(req_exp_q.size()), 96'(0));
        chk("wb_queue_drained", 96'(wb_exp_q.size()), 96'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
